// File: rtl/dropout_mask_gen.sv
// rtl/dropout_mask_gen.sv - PRNG-driven dropout/keep mask generator with valid/ready output
module dropout_mask_gen #(
  parameter int RAND_WIDTH  = 32,
  parameter int SLICE_WIDTH = 8,
  parameter int MASK_WIDTH  = 64
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [SLICE_WIDTH-1:0] keep_threshold,
  output logic                   rng_enable,
  output logic                   rng_fetch,
  input  logic [RAND_WIDTH-1:0]  rng_data,
  output logic [MASK_WIDTH-1:0]  mask,
  output logic                   mask_valid,
  input  logic                   mask_ready,
  output logic                   busy
);

  localparam int SPW   = RAND_WIDTH / SLICE_WIDTH;
  localparam int WORDS = MASK_WIDTH / SPW;
  localparam int FW    = $clog2(WORDS + 1);
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t                 state;
  logic [FW-1:0]          fetch_cnt;
  logic [CW-1:0]          cap_cnt;
  logic [SLICE_WIDTH-1:0] thr_q;
  logic                   fetch_d;
  logic [SPW-1:0]         word_bits;

  // One keep bit per slice of the returned word: keep when slice < threshold
  for (genvar g = 0; g < SPW; g++) begin : g_slice
    assign word_bits[g] = (rng_data[g*SLICE_WIDTH +: SLICE_WIDTH] < thr_q);
  end

  // Fetch requests are issued back to back until WORDS words have been asked for
  assign rng_fetch  = (state == GEN) && (fetch_cnt < FW'(WORDS));
  assign rng_enable = rng_fetch;
  assign busy       = (state != IDLE);

  // Request FSM; words are shifted in from the top so word 0 ends up in the low bits
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      mask       <= '0;
      mask_valid <= 1'b0;
      fetch_cnt  <= '0;
      cap_cnt    <= '0;
      thr_q      <= '0;
      fetch_d    <= 1'b0;
    end else begin
      fetch_d <= rng_fetch;
      case (state)
        IDLE: begin
          if (start) begin
            thr_q     <= keep_threshold;
            fetch_cnt <= '0;
            cap_cnt   <= '0;
            mask      <= '0;
            state     <= GEN;
          end
        end
        GEN: begin
          if (rng_fetch) begin
            fetch_cnt <= fetch_cnt + 1'b1;
          end
          if (fetch_d) begin
            mask    <= {word_bits, mask[MASK_WIDTH-1:SPW]};
            cap_cnt <= cap_cnt + 1'b1;
            if (cap_cnt == CW'(WORDS - 1)) begin
              mask_valid <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (mask_ready) begin
            mask_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dropout_mask_gen.sv
// tb/tb_dropout_mask_gen.sv - scoreboard testbench for dropout_mask_gen
module tb_dropout_mask_gen;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [7:0]  keep_threshold;
  logic        rng_enable;
  logic        rng_fetch;
  logic [31:0] rng_data;
  logic [63:0] mask;
  logic        mask_valid;
  logic        mask_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int fetch_total = 0;
  logic fetch_prev = 1'b0;

  logic [31:0] word_q[$];
  logic [63:0] exp_q[$];

  dropout_mask_gen dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .keep_threshold (keep_threshold),
    .rng_enable     (rng_enable),
    .rng_fetch      (rng_fetch),
    .rng_data       (rng_data),
    .mask           (mask),
    .mask_valid     (mask_valid),
    .mask_ready     (mask_ready),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PRNG model: count fetches mid-cycle
  always @(negedge clock) begin
    fetch_prev = rng_fetch;
    if (rng_fetch) fetch_total++;
  end

  // PRNG model: word for a fetch appears the cycle after it; garbage otherwise
  always @(posedge clock) begin
    #1;
    if (fetch_prev && word_q.size() > 0) rng_data = word_q.pop_front();
    else rng_data = $urandom;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Queue the words the PRNG will return for one request and the mask they must produce
  task automatic build_req(input logic [7:0] thr, input bit rnd, input logic [31:0] cval);
    logic [63:0] m;
    logic [31:0] w;
    logic [7:0]  s;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      w = rnd ? $urandom : cval;
      word_q.push_back(w);
      for (int k = 0; k < 4; k++) begin
        s = w[k*8 +: 8];
        m[i*4+k] = (s < thr);
      end
    end
    exp_q.push_back(m);
  endtask

  task automatic pop_expected(output logic [63:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e = 'x;
      check("scoreboard_empty", 64'd1, 64'd0);
    end
  endtask

  task automatic run_req(input string nm, input logic [7:0] thr, input bit rnd,
                         input logic [31:0] cval, input int bp);
    int edges;
    int base;
    logic [63:0] exp_m;
    logic [63:0] held;
    build_req(thr, rnd, cval);
    @(negedge clock);
    start = 1'b1;
    keep_threshold = thr;
    base = fetch_total;
    @(posedge clock); #1;
    start = 1'b0;
    keep_threshold = ~thr;
    edges = 0;
    while (!mask_valid && edges < 100) begin
      @(posedge clock); #1;
      edges++;
    end
    check({nm, "_latency"}, 64'(edges), 64'd17);
    pop_expected(exp_m);
    check({nm, "_mask"}, mask, exp_m);
    check({nm, "_fetches"}, 64'(fetch_total - base), 64'd16);
    held = mask;
    for (int i = 0; i < bp; i++) begin
      @(negedge clock);
      start = 1'b1;
      keep_threshold = 8'($urandom);
      @(posedge clock); #1;
      check({nm, "_bp_mask"}, mask, held);
      check({nm, "_bp_valid"}, 64'(mask_valid), 64'd1);
      check({nm, "_bp_fetch"}, 64'(rng_fetch), 64'd0);
      check({nm, "_bp_busy"}, 64'(busy), 64'd1);
    end
    @(negedge clock);
    mask_ready = 1'b1;
    start = (bp > 0);
    @(posedge clock); #1;
    check({nm, "_hs_valid"}, 64'(mask_valid), 64'd0);
    check({nm, "_hs_busy"}, 64'(busy), 64'd0);
    check({nm, "_hs_mask_kept"}, mask, held);
    @(negedge clock);
    mask_ready = 1'b0;
    start = 1'b0;
    @(posedge clock); #1;
    check({nm, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    int edges;
    int base;
    logic [7:0]  thr_list[3];
    logic [63:0] exp_m;

    reset_n = 1'b0;
    start = 1'b0;
    keep_threshold = 8'h00;
    mask_ready = 1'b0;
    rng_data = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(mask_valid), 64'd0);
    check("reset_mask", mask, 64'd0);
    check("reset_fetch", 64'(rng_fetch), 64'd0);
    check("reset_enable", 64'(rng_enable), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_req("thr0", 8'h00, 1'b1, 32'h0, 0);
    run_req("half", 8'h80, 1'b0, 32'h807F00FF, 0);
    run_req("ff_ff", 8'hFF, 1'b0, 32'hFFFFFFFF, 0);
    run_req("ff_fe", 8'hFE, 1'b0, 32'hFFFFFFFF, 0);
    run_req("fe_ff", 8'hFF, 1'b0, 32'hFEFEFEFE, 0);
    run_req("backpressure", 8'h5A, 1'b1, 32'h0, 10);

    // Reset in the middle of generation
    build_req(8'h80, 1'b0, 32'h807F00FF);
    @(negedge clock);
    start = 1'b1;
    keep_threshold = 8'h80;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    guard = 0;
    while (n < 5 && guard < 50) begin
      @(negedge clock);
      guard++;
      if (rng_fetch) n++;
    end
    check("rst_reach_fetch5", 64'(n), 64'd5);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fetch", 64'(rng_fetch), 64'd0);
    check("rst_valid", 64'(mask_valid), 64'd0);
    check("rst_mask", mask, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    word_q.delete();
    exp_q.delete();
    @(posedge clock); #1;
    check("rst_stay_idle", 64'(busy), 64'd0);
    run_req("post_rst", 8'h80, 1'b0, 32'h807F00FF, 0);

    // Back-to-back requests with start held high
    thr_list[0] = 8'h40;
    thr_list[1] = 8'hC0;
    thr_list[2] = 8'h10;
    for (int i = 0; i < 3; i++) build_req(thr_list[i], 1'b1, 32'h0);
    @(negedge clock);
    start = 1'b1;
    mask_ready = 1'b1;
    keep_threshold = thr_list[0];
    base = fetch_total;
    for (int i = 0; i < 3; i++) begin
      edges = 0;
      while (!mask_valid && edges < 100) begin
        @(posedge clock); #1;
        edges++;
      end
      check("b2b_gap", 64'(edges), 64'd18);
      pop_expected(exp_m);
      check("b2b_mask", mask, exp_m);
      check("b2b_fetches", 64'(fetch_total - base), 64'd16);
      @(negedge clock);
      if (i < 2) keep_threshold = thr_list[i+1];
      else start = 1'b0;
      base = fetch_total;
      @(posedge clock); #1;
      check("b2b_idle_busy", 64'(busy), 64'd0);
      check("b2b_idle_valid", 64'(mask_valid), 64'd0);
    end
    @(negedge clock);
    mask_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      run_req("random", 8'($urandom), 1'b1, 32'h0, i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
